coffee_vend_controller: RTL and testbench

Sequential successor to the combinational coffee price/change check. It accumulates coins, validates an order against a parametrised price table, and runs a brew timer. It then dispenses change one coin per cycle and supports order cancel with full refund. It sits between the coin-acceptor debounce logic and the brew-valve/change-hopper drivers.

---
 rtl/coffee_vend_controller_if.sv | 28 ++
 rtl/coffee_vend_controller.sv | 160 ++++++++++++++++
 tb/tb_coffee_vend_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/coffee_vend_controller_if.sv
// Coin-acceptor / drink-request side and valve/hopper side of the vending controller.
// The slave modport is the controller; the master modport is whoever drives it.
interface coffee_vend_controller_if #(
   parameter int unsigned COIN_W = 4,
   parameter int unsigned TYPE_W = 2
);
   logic              coin_in;
   logic [TYPE_W-1:0] coffee_type;
   logic              order;
   logic              cancel;
   logic [COIN_W-1:0] total_coins;
   logic [COIN_W-1:0] change_left;
   logic              change_pulse;
   logic              brewing;
   logic              done;
   logic              insufficient;
   logic              coin_reject;

   modport master (
      output coin_in, coffee_type, order, cancel,
      input  total_coins, change_left, change_pulse, brewing, done, insufficient, coin_reject
   );

   modport slave (
      input  coin_in, coffee_type, order, cancel,
      output total_coins, change_left, change_pulse, brewing, done, insufficient, coin_reject
   );
endinterface

// File: rtl/coffee_vend_controller.sv
// Coin accumulator, price check, brew timer and one-coin-per-cycle change dispenser.
// All outputs are registered; reset aborts any brew or payout and discards credit.
module coffee_vend_controller #(
   parameter int unsigned COIN_W      = 4,
   parameter int unsigned TYPE_W      = 2,
   parameter int unsigned PRICE0      = 3,
   parameter int unsigned PRICE1      = 4,
   parameter int unsigned PRICE2      = 5,
   parameter int unsigned PRICE3      = 7,
   parameter int unsigned BREW_CYCLES = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   coffee_vend_controller_if.slave bus
);

   localparam int unsigned CREDIT_MAX = (1 << COIN_W) - 1;

   if (PRICE0 > CREDIT_MAX || PRICE1 > CREDIT_MAX || PRICE2 > CREDIT_MAX ||
       PRICE3 > CREDIT_MAX) begin : g_price_ovf
      $warning("coffee_vend_controller: a price exceeds the credit limit; drink is unorderable");
   end
   if (BREW_CYCLES < 1 || BREW_CYCLES > 65535) begin : g_brew_range
      $error("coffee_vend_controller: BREW_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {StCollect, StBrew, StChange} state_e;

   state_e            state_q, state_d;
   logic [COIN_W-1:0] total_q, total_d;
   logic [COIN_W-1:0] change_q, change_d;
   logic [15:0]       brew_cnt_q, brew_cnt_d;
   logic              from_brew_q, from_brew_d;
   logic              change_pulse_q, change_pulse_d;
   logic              brewing_q, brewing_d;
   logic              done_q, done_d;
   logic              insufficient_q, insufficient_d;
   logic              coin_reject_q, coin_reject_d;

   int unsigned price;
   logic        price_ok;
   logic        affordable;

   always_comb begin
      price    = 0;
      price_ok = 1'b1;
      case (int'(bus.coffee_type))
         0:       price = PRICE0;
         1:       price = PRICE1;
         2:       price = PRICE2;
         3:       price = PRICE3;
         default: price_ok = 1'b0;
      endcase
      affordable = price_ok && (32'(total_q) >= price);
   end

   always_comb begin
      state_d        = state_q;
      total_d        = total_q;
      change_d       = change_q;
      brew_cnt_d     = brew_cnt_q;
      from_brew_d    = from_brew_q;
      change_pulse_d = 1'b0;
      brewing_d      = 1'b0;
      done_d         = 1'b0;
      insufficient_d = 1'b0;
      coin_reject_d  = 1'b0;

      unique case (state_q)
         StCollect: begin
            if (bus.cancel) begin
               change_d      = total_q;
               total_d       = '0;
               coin_reject_d = bus.coin_in;
               if (total_q != '0) begin
                  state_d        = StChange;
                  change_pulse_d = 1'b1;
                  from_brew_d    = 1'b0;
               end
            end else if (bus.order && affordable) begin
               change_d      = total_q - COIN_W'(price);
               total_d       = '0;
               brew_cnt_d    = 16'(BREW_CYCLES);
               brewing_d     = 1'b1;
               coin_reject_d = bus.coin_in;
               state_d       = StBrew;
            end else begin
               insufficient_d = bus.order;
               if (bus.coin_in) begin
                  if (total_q == '1) coin_reject_d = 1'b1;
                  else               total_d       = total_q + 1'b1;
               end
            end
         end
         StBrew: begin
            coin_reject_d = bus.coin_in;
            brew_cnt_d    = brew_cnt_q - 16'd1;
            if (brew_cnt_q <= 16'd1) begin
               if (change_q != '0) begin
                  state_d        = StChange;
                  change_pulse_d = 1'b1;
                  from_brew_d    = 1'b1;
               end else begin
                  state_d = StCollect;
                  done_d  = 1'b1;
               end
            end else begin
               brewing_d = 1'b1;
            end
         end
         StChange: begin
            coin_reject_d = bus.coin_in;
            change_d      = change_q - 1'b1;
            if (change_q <= COIN_W'(1)) begin
               change_d = '0;
               state_d  = StCollect;
               done_d   = from_brew_q;
            end else begin
               change_pulse_d = 1'b1;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StCollect;
         total_q        <= '0;
         change_q       <= '0;
         brew_cnt_q     <= '0;
         from_brew_q    <= 1'b0;
         change_pulse_q <= 1'b0;
         brewing_q      <= 1'b0;
         done_q         <= 1'b0;
         insufficient_q <= 1'b0;
         coin_reject_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         total_q        <= total_d;
         change_q       <= change_d;
         brew_cnt_q     <= brew_cnt_d;
         from_brew_q    <= from_brew_d;
         change_pulse_q <= change_pulse_d;
         brewing_q      <= brewing_d;
         done_q         <= done_d;
         insufficient_q <= insufficient_d;
         coin_reject_q  <= coin_reject_d;
      end
   end

   assign bus.total_coins  = total_q;
   assign bus.change_left  = change_q;
   assign bus.change_pulse = change_pulse_q;
   assign bus.brewing      = brewing_q;
   assign bus.done         = done_q;
   assign bus.insufficient = insufficient_q;
   assign bus.coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_coffee_vend_controller.sv
// Directed scenarios plus random coin/order/cancel traffic checked against a
// schedule-based model: an accepted order or refund expands into a list of future output cycles.
module tb_coffee_vend_controller;

   localparam int unsigned COIN_W = 4;
   localparam int unsigned TYPE_W = 2;
   localparam int unsigned BREW   = 4;
   localparam int          MAXC   = (1 << COIN_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   coffee_vend_controller_if #(.COIN_W(COIN_W), .TYPE_W(TYPE_W)) bus ();

   coffee_vend_controller #(
      .COIN_W(COIN_W), .TYPE_W(TYPE_W), .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(7),
      .BREW_CYCLES(BREW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      bit brew;
      bit pulse;
      int left;
   } slot_t;

   slot_t plan[$];
   int    credit;
   bit    busy;
   bit    pending_done;
   int    exp_total, exp_left;
   bit    exp_brew, exp_pulse, exp_done, exp_insuf, exp_rej;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int price_of(input int t);
      case (t)
         0:       return 3;
         1:       return 4;
         2:       return 5;
         3:       return 7;
         default: return -1;
      endcase
   endfunction

   function automatic void model_reset();
      plan.delete();
      credit       = 0;
      busy         = 1'b0;
      pending_done = 1'b0;
      exp_total    = 0;
      exp_left     = 0;
      {exp_brew, exp_pulse, exp_done, exp_insuf, exp_rej} = '0;
   endfunction

   function automatic void start_plan();
      slot_t s;
      s         = plan.pop_front();
      exp_brew  = s.brew;
      exp_pulse = s.pulse;
      exp_left  = s.left;
      busy      = 1'b1;
   endfunction

   function automatic void model_edge(input bit c, input int t, input bit o, input bit x);
      int p;
      int ch;
      exp_done  = 1'b0;
      exp_insuf = 1'b0;
      exp_rej   = 1'b0;
      p         = price_of(t);
      if (busy) begin
         exp_rej = c;
         if (plan.size() > 0) begin
            start_plan();
         end else begin
            busy      = 1'b0;
            exp_brew  = 1'b0;
            exp_pulse = 1'b0;
            exp_left  = 0;
            exp_done  = pending_done;
         end
      end else begin
         exp_brew  = 1'b0;
         exp_pulse = 1'b0;
         exp_left  = 0;
         if (x) begin
            exp_rej = c;
            if (credit > 0) begin
               for (int k = 0; k < credit; k++) plan.push_back('{brew: 1'b0, pulse: 1'b1, left: credit - k});
               pending_done = 1'b0;
               credit       = 0;
               start_plan();
            end
         end else if (o && p >= 0 && credit >= p) begin
            exp_rej = c;
            ch      = credit - p;
            for (int k = 0; k < int'(BREW); k++) plan.push_back('{brew: 1'b1, pulse: 1'b0, left: ch});
            for (int k = 0; k < ch; k++) plan.push_back('{brew: 1'b0, pulse: 1'b1, left: ch - k});
            pending_done = 1'b1;
            credit       = 0;
            start_plan();
         end else begin
            exp_insuf = o;
            if (c) begin
               if (credit == MAXC) exp_rej = 1'b1;
               else                credit++;
            end
         end
      end
      exp_total = credit;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".total"}, int'(bus.total_coins), exp_total);
      check({tag, ".left"},  int'(bus.change_left), exp_left);
      check({tag, ".pulse"}, int'(bus.change_pulse), int'(exp_pulse));
      check({tag, ".brew"},  int'(bus.brewing), int'(exp_brew));
      check({tag, ".done"},  int'(bus.done), int'(exp_done));
      check({tag, ".insuf"}, int'(bus.insufficient), int'(exp_insuf));
      check({tag, ".rej"},   int'(bus.coin_reject), int'(exp_rej));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".total"}, int'(bus.total_coins), 0);
      check({tag, ".left"},  int'(bus.change_left), 0);
      check({tag, ".pulse"}, int'(bus.change_pulse), 0);
      check({tag, ".brew"},  int'(bus.brewing), 0);
      check({tag, ".done"},  int'(bus.done), 0);
      check({tag, ".insuf"}, int'(bus.insufficient), 0);
      check({tag, ".rej"},   int'(bus.coin_reject), 0);
   endtask

   task automatic step(input string tag, input bit c, input int t, input bit o, input bit x);
      bus.coin_in     = c;
      bus.coffee_type = TYPE_W'(t);
      bus.order       = o;
      bus.cancel      = x;
      @(posedge clk);
      model_edge(c, t, o, x);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic coins(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b1, 0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.coin_in     = 1'b0;
      bus.coffee_type = '0;
      bus.order       = 1'b0;
      bus.cancel      = 1'b0;
      rst_n           = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Exact fit, no change
      coins("p1coin", 3);
      step("p1order", 1'b0, 0, 1'b1, 1'b0);
      idle("p1run", BREW + 2);

      // Change after brew
      coins("p2coin", 9);
      step("p2order", 1'b0, 3, 1'b1, 1'b0);
      idle("p2run", BREW + 4);

      // Insufficient then refund
      coins("p3coin", 4);
      step("p3insuf", 1'b0, 2, 1'b1, 1'b0);
      step("p3cancel", 1'b0, 0, 1'b0, 1'b1);
      idle("p3run", 6);

      // Saturation and coin during brew
      coins("p4coin", 16);
      step("p4order", 1'b0, 3, 1'b1, 1'b0);
      step("p4brewcoin", 1'b1, 0, 1'b0, 1'b0);
      idle("p4run", BREW + 10);

      // Same-cycle priority
      coins("p5coin", 5);
      step("p5cancel", 1'b1, 1, 1'b1, 1'b1);
      idle("p5run", 7);
      coins("p5bcoin", 3);
      step("p5ordcoin", 1'b1, 0, 1'b1, 1'b0);
      idle("p5brun", BREW + 2);

      // Random traffic; order rate varies per burst so saturation is also reached
      for (int i = 0; i < 3000; i++) begin
         int op;
         op = ((i / 200) % 3 == 0) ? 20 : (((i / 200) % 3 == 1) ? 2 : 10);
         step("rand", ($urandom % 100) < 55, int'($urandom_range(0, 3)),
              ($urandom % 100) < op, ($urandom % 100) < 3);
      end
      idle("drain", 30);

      // Asynchronous reset in the second brew cycle
      coins("rcoin", 3);
      step("rorder", 1'b0, 0, 1'b1, 1'b0);
      step("rbrew2", 1'b0, 0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle("postreset", 3);
      coins("postcoin", 2);
      idle("postidle", 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
